// File: rtl/fd_hazard_ctrl_pkg.sv
// Shared constants, state encoding and control-word type for the front-end
// hazard controller of the 5-stage 16-bit core.
package fd_hazard_ctrl_pkg;

    localparam int PC_W       = 16;
    localparam int REG_ADDR_W = 3;
    localparam int PERF_W     = 16;

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FLUSH2 = 2'd2,
        ST_HALT   = 2'd3
    } fd_state_t;

    typedef struct packed {
        logic pc_we;
        logic pc_sel;
        logic fd_we;
        logic fd_flush;
        logic fd_flush_second;
        logic de_bubble;
    } fd_ctrl_t;

    localparam fd_ctrl_t CTRL_IDLE = '{
        pc_we: 1'b0, pc_sel: 1'b0, fd_we: 1'b0,
        fd_flush: 1'b0, fd_flush_second: 1'b0, de_bubble: 1'b0
    };

    localparam fd_ctrl_t CTRL_BOOT = '{
        pc_we: 1'b1, pc_sel: 1'b0, fd_we: 1'b1,
        fd_flush: 1'b1, fd_flush_second: 1'b0, de_bubble: 1'b1
    };

    localparam fd_ctrl_t CTRL_REDIRECT = '{
        pc_we: 1'b1, pc_sel: 1'b1, fd_we: 1'b1,
        fd_flush: 1'b1, fd_flush_second: 1'b0, de_bubble: 1'b1
    };

    localparam fd_ctrl_t CTRL_LOAD_USE = '{
        pc_we: 1'b0, pc_sel: 1'b0, fd_we: 1'b0,
        fd_flush: 1'b0, fd_flush_second: 1'b0, de_bubble: 1'b1
    };

    // Shared by halt-in-ID and imem stall: hold PC, push a NOP into F/D.
    localparam fd_ctrl_t CTRL_FETCH_NOP = '{
        pc_we: 1'b0, pc_sel: 1'b0, fd_we: 1'b1,
        fd_flush: 1'b1, fd_flush_second: 1'b0, de_bubble: 1'b0
    };

    localparam fd_ctrl_t CTRL_NORMAL = '{
        pc_we: 1'b1, pc_sel: 1'b0, fd_we: 1'b1,
        fd_flush: 1'b0, fd_flush_second: 1'b0, de_bubble: 1'b0
    };

    localparam fd_ctrl_t CTRL_SECOND = '{
        pc_we: 1'b1, pc_sel: 1'b0, fd_we: 1'b1,
        fd_flush: 1'b0, fd_flush_second: 1'b1, de_bubble: 1'b0
    };

    localparam fd_ctrl_t CTRL_HALTED = '{
        pc_we: 1'b0, pc_sel: 1'b0, fd_we: 1'b0,
        fd_flush: 1'b0, fd_flush_second: 1'b0, de_bubble: 1'b1
    };

    function automatic logic load_use_hazard(
        input logic                  ex_is_load,
        input logic [REG_ADDR_W-1:0] ex_rd,
        input logic                  rs_valid,
        input logic [REG_ADDR_W-1:0] rs,
        input logic                  rt_valid,
        input logic [REG_ADDR_W-1:0] rt
    );
        return ex_is_load && ((rs_valid && (rs == ex_rd)) ||
                              (rt_valid && (rt == ex_rd)));
    endfunction

endpackage

// File: rtl/fd_hazard_ctrl_if.sv
// Hazard inputs from ID/EX/MEM and fetch-side control outputs of the
// front-end controller; the controller side uses the slave modport.
interface fd_hazard_ctrl_if;
    import fd_hazard_ctrl_pkg::*;

    logic                  imem_stall;
    logic                  dmem_stall;
    logic                  ex_redirect;
    logic                  ex_is_load;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  id_rs_valid;
    logic                  id_rt_valid;
    logic [REG_ADDR_W-1:0] id_rs;
    logic [REG_ADDR_W-1:0] id_rt;
    logic                  id_halt;

    logic                  pc_we;
    logic                  pc_sel;
    logic                  fd_we;
    logic                  fd_flush;
    logic                  fd_flush_second;
    logic                  de_bubble;
    logic [PERF_W-1:0]     stall_cnt;
    logic [PERF_W-1:0]     flush_cnt;

    modport master (
        output imem_stall, dmem_stall, ex_redirect, ex_is_load, ex_rd,
               id_rs_valid, id_rt_valid, id_rs, id_rt, id_halt,
        input  pc_we, pc_sel, fd_we, fd_flush, fd_flush_second, de_bubble,
               stall_cnt, flush_cnt
    );

    modport slave (
        input  imem_stall, dmem_stall, ex_redirect, ex_is_load, ex_rd,
               id_rs_valid, id_rt_valid, id_rs, id_rt, id_halt,
        output pc_we, pc_sel, fd_we, fd_flush, fd_flush_second, de_bubble,
               stall_cnt, flush_cnt
    );

endinterface

// File: rtl/fd_hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the front-end performance counters;
// sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/fd_hazard_ctrl.sv
// Front-end pipeline controller: resolves memory stalls, EX redirects,
// load-use hazards and halt into PC/F-D/D-X control, plus perf counters.
module fd_hazard_ctrl
    import fd_hazard_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    fd_hazard_ctrl_if.slave  bus
);

    fd_state_t state_q;
    fd_state_t state_d;
    fd_ctrl_t  ctrl;
    logic      hazard;
    logic      stall_inc;
    logic      flush_inc;

    assign hazard = load_use_hazard(bus.ex_is_load, bus.ex_rd,
                                    bus.id_rs_valid, bus.id_rs,
                                    bus.id_rt_valid, bus.id_rt);

    // Outputs are a pure function of state and this cycle's hazard inputs.
    always_comb begin
        ctrl      = CTRL_IDLE;
        state_d   = state_q;
        flush_inc = 1'b0;
        case (state_q)
            ST_BOOT: begin
                ctrl    = CTRL_BOOT;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (bus.dmem_stall) begin
                    ctrl = CTRL_IDLE;
                end else if (bus.ex_redirect) begin
                    ctrl      = CTRL_REDIRECT;
                    state_d   = ST_FLUSH2;
                    flush_inc = 1'b1;
                end else if (hazard) begin
                    ctrl = CTRL_LOAD_USE;
                end else if (bus.id_halt) begin
                    ctrl    = CTRL_FETCH_NOP;
                    state_d = ST_HALT;
                end else if (bus.imem_stall) begin
                    ctrl = CTRL_FETCH_NOP;
                end else begin
                    ctrl = CTRL_NORMAL;
                end
            end
            ST_FLUSH2: begin
                // A frozen FLUSH2 keeps the second flush pending until memory frees up.
                if (bus.dmem_stall) begin
                    ctrl = CTRL_IDLE;
                end else if (bus.ex_redirect) begin
                    ctrl      = CTRL_REDIRECT;
                    flush_inc = 1'b1;
                end else begin
                    ctrl    = CTRL_SECOND;
                    state_d = ST_RUN;
                end
            end
            ST_HALT: begin
                ctrl = CTRL_HALTED;
            end
        endcase
    end

    assign stall_inc = (state_q == ST_RUN) && !ctrl.pc_we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    sat_counter #(.WIDTH(PERF_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_inc),
        .count (bus.stall_cnt)
    );

    sat_counter #(.WIDTH(PERF_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (flush_inc),
        .count (bus.flush_cnt)
    );

    assign bus.pc_we           = ctrl.pc_we;
    assign bus.pc_sel          = ctrl.pc_sel;
    assign bus.fd_we           = ctrl.fd_we;
    assign bus.fd_flush        = ctrl.fd_flush;
    assign bus.fd_flush_second = ctrl.fd_flush_second;
    assign bus.de_bubble       = ctrl.de_bubble;

endmodule

// File: tb/tb_fd_hazard_ctrl.sv
// Directed and randomized checks of fd_hazard_ctrl against a flag-based
// behavioural model of the front-end control rules.
module tb_fd_hazard_ctrl;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    fd_hazard_ctrl_if bus ();

    fd_hazard_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model: which situation the front end is in, plus counter values.
    bit m_boot;
    bit m_halt;
    bit m_second;
    int m_stall;
    int m_flush;

    logic [5:0] e_vec;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit modelHazard();
        return bus.ex_is_load &&
               ((bus.id_rs_valid && bus.id_rs == bus.ex_rd) ||
                (bus.id_rt_valid && bus.id_rt == bus.ex_rd));
    endfunction

    // Expected {pc_we, pc_sel, fd_we, fd_flush, fd_flush_second, de_bubble}.
    task automatic modelOutputs();
        if (m_boot)                 e_vec = 6'b101101;
        else if (m_halt)            e_vec = 6'b000001;
        else if (m_second) begin
            if (bus.dmem_stall)       e_vec = 6'b000000;
            else if (bus.ex_redirect) e_vec = 6'b111101;
            else                      e_vec = 6'b101010;
        end else begin
            if (bus.dmem_stall)       e_vec = 6'b000000;
            else if (bus.ex_redirect) e_vec = 6'b111101;
            else if (modelHazard())   e_vec = 6'b000001;
            else if (bus.id_halt)     e_vec = 6'b001100;
            else if (bus.imem_stall)  e_vec = 6'b001100;
            else                      e_vec = 6'b101000;
        end
    endtask

    function automatic int satInc(input int v);
        return (v < 65535) ? v + 1 : 65535;
    endfunction

    task automatic modelAdvance();
        if (m_boot) begin
            m_boot = 1'b0;
        end else if (m_halt) begin
        end else if (m_second) begin
            if (!bus.dmem_stall) begin
                if (bus.ex_redirect) m_flush = satInc(m_flush);
                else                 m_second = 1'b0;
            end
        end else begin
            if (e_vec[5] == 1'b0) m_stall = satInc(m_stall);
            if (!bus.dmem_stall) begin
                if (bus.ex_redirect) begin
                    m_flush  = satInc(m_flush);
                    m_second = 1'b1;
                end else if (modelHazard()) begin
                end else if (bus.id_halt) begin
                    m_halt = 1'b1;
                end
            end
        end
    endtask

    task automatic modelReset();
        m_boot   = 1'b1;
        m_halt   = 1'b0;
        m_second = 1'b0;
        m_stall  = 0;
        m_flush  = 0;
    endtask

    task automatic applyStimulus(input logic imem, input logic dmem, input logic redir,
                                 input logic ld, input logic [2:0] rd,
                                 input logic rsv, input logic [2:0] rs,
                                 input logic rtv, input logic [2:0] rt,
                                 input logic halt);
        bus.imem_stall  = imem;
        bus.dmem_stall  = dmem;
        bus.ex_redirect = redir;
        bus.ex_is_load  = ld;
        bus.ex_rd       = rd;
        bus.id_rs_valid = rsv;
        bus.id_rs       = rs;
        bus.id_rt_valid = rtv;
        bus.id_rt       = rt;
        bus.id_halt     = halt;
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 0, 3'd0, 0, 3'd1, 0, 3'd2, 0);
    endtask

    task automatic checkOutput(input string tag);
        modelOutputs();
        check({tag, ".pc_we"},           16'(bus.pc_we),           16'(e_vec[5]));
        check({tag, ".pc_sel"},          16'(bus.pc_sel),          16'(e_vec[4]));
        check({tag, ".fd_we"},           16'(bus.fd_we),           16'(e_vec[3]));
        check({tag, ".fd_flush"},        16'(bus.fd_flush),        16'(e_vec[2]));
        check({tag, ".fd_flush_second"}, 16'(bus.fd_flush_second), 16'(e_vec[1]));
        check({tag, ".de_bubble"},       16'(bus.de_bubble),       16'(e_vec[0]));
        check({tag, ".stall_cnt"},       bus.stall_cnt,            16'(m_stall));
        check({tag, ".flush_cnt"},       bus.flush_cnt,            16'(m_flush));
    endtask

    task automatic cycle(input string tag);
        @(negedge clk);
        checkOutput(tag);
        @(posedge clk);
        modelAdvance();
        #1;
    endtask

    // Reset is asserted asynchronously just after an edge and held a few cycles.
    task automatic doReset(input int n);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        idle();
        modelReset();
        #1;
        checkOutput("reset_async");
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            checkOutput("reset_hold");
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1;
        idle();
        modelReset();

        doReset(3);
        cycle("boot");
        cycle("run_first");

        applyStimulus(0, 0, 0, 1, 3'd3, 1, 3'd3, 0, 3'd0, 0);
        cycle("load_use");
        idle();
        cycle("after_load_use");
        check("stall_cnt_one", bus.stall_cnt, 16'd1);

        applyStimulus(0, 0, 1, 0, 3'd0, 0, 3'd0, 0, 3'd0, 0);
        cycle("redirect_n");
        idle();
        cycle("redirect_n1");
        cycle("redirect_n2");
        check("flush_cnt_one", bus.flush_cnt, 16'd1);

        applyStimulus(0, 0, 1, 0, 3'd0, 0, 3'd0, 0, 3'd0, 0);
        cycle("redir_dm_n");
        applyStimulus(0, 1, 0, 0, 3'd0, 0, 3'd0, 0, 3'd0, 0);
        for (int i = 0; i < 3; i++) cycle("redir_dm_frozen");
        idle();
        cycle("redir_dm_second");
        cycle("redir_dm_run");

        applyStimulus(0, 0, 1, 0, 3'd0, 0, 3'd0, 0, 3'd0, 0);
        cycle("redir_again");
        cycle("redir_in_flush2");
        applyStimulus(0, 0, 0, 0, 3'd0, 0, 3'd0, 0, 3'd0, 1);
        cycle("halt_ignored_flush2");
        cycle("halt_taken");
        idle();
        for (int i = 0; i < 4; i++) cycle("halted");
        doReset(1);
        cycle("boot_after_halt");

        applyStimulus(0, 0, 1, 0, 3'd0, 0, 3'd0, 0, 3'd0, 0);
        cycle("redir_before_reset");
        doReset(1);
        cycle("boot_after_flush2_reset");
        cycle("run_after_flush2_reset");

        for (int i = 0; i < 600; i++) begin
            applyStimulus(($urandom_range(0, 4) == 0), ($urandom_range(0, 5) == 0),
                          ($urandom_range(0, 5) == 0), ($urandom_range(0, 2) == 0),
                          3'($urandom_range(0, 7)),
                          1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                          1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                          ($urandom_range(0, 39) == 0));
            cycle("random");
            if (m_halt && $urandom_range(0, 3) == 0) begin
                doReset(1);
            end
        end

        doReset(2);
        cycle("sat_boot");
        applyStimulus(0, 0, 0, 1, 3'd5, 0, 3'd0, 1, 3'd5, 0);
        for (int i = 0; i < 70000; i++) cycle("saturate");
        check("stall_cnt_saturated", bus.stall_cnt, 16'hFFFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fd_hazard_ctrl.md
# fd_hazard_ctrl

Front-end pipeline controller for the 5-stage 16-bit core. It owns PC update, the F/D register write enable and the F/D two-stage flush markers (`fd_flush`, `fd_flush_second`). It also owns the bubble injection into D/X, so that load-use hazards, EX-stage branch redirects, memory stalls and halt are resolved in one place. It sits between the hazard inputs from ID/EX/MEM and the fetch datapath. It also keeps two saturating performance counters.

## Interface
- No parameters. Shared constants `PC_W = 16` and `REG_ADDR_W = 3` are taken from the package.
- `clk  in  1` core clock; all state updates on rising edge.
- `rst_n  in  1` asynchronous reset, active low.
- `imem_stall  in  1` instruction memory has not returned a word this cycle.
- `dmem_stall  in  1` data memory busy; the whole front end freezes.
- `ex_redirect  in  1` taken branch or jump resolved in EX this cycle.
- `ex_is_load  in  1` instruction in EX is a load.
- `ex_rd  in  3` destination register of the instruction in EX.
- `id_rs_valid, id_rt_valid  in  1` the instruction in ID reads rs / rt.
- `id_rs, id_rt  in  3` source registers of the instruction in ID.
- `id_halt  in  1` instruction in ID is HALT.
- `pc_we  out  1` PC register write enable.
- `pc_sel  out  1` 1 selects the redirect target, 0 selects PC+2.
- `fd_we  out  1` F/D register write enable.
- `fd_flush  out  1` marks the word entering F/D as a NOP.
- `fd_flush_second  out  1` second-cycle flush marker for F/D.
- `de_bubble  out  1` forces NOP into D/X.
- `stall_cnt  out  16` saturating count of cycles with `pc_we=0` in RUN.
- `flush_cnt  out  16` saturating count of redirects taken.

## Operation
- States: BOOT, RUN, FLUSH2, HALT. The state register is asynchronous-reset to BOOT.
- Load-use hazard: `ex_is_load` and ((`id_rs_valid` and `id_rs==ex_rd`) or (`id_rt_valid` and `id_rt==ex_rd`)).
- BOOT (one cycle): `pc_we=1`, `fd_we=1`, `fd_flush=1`, `de_bubble=1`. Next state is RUN. This is because the synchronous imem has not yet produced a word.
- RUN has a fixed priority order; the first matching row applies:
  1. `dmem_stall`: all enables 0, flush outputs 0. Stay in RUN.
  2. `ex_redirect`: `pc_we=1`, `pc_sel=1`, `fd_we=1`, `fd_flush=1`, `de_bubble=1`. Go to FLUSH2.
  3. Load-use hazard: `pc_we=0`, `fd_we=0`, `de_bubble=1`.
  4. `id_halt`: `pc_we=0`, `fd_we=1`, `fd_flush=1`. Go to HALT.
  5. `imem_stall`: `pc_we=0`, `fd_we=1`, `fd_flush=1`.
  6. Otherwise: `pc_we=1`, `fd_we=1`, all flushes 0.
- FLUSH2: `fd_flush_second=1`, `pc_we=1`, `fd_we=1`. This kills the word fetched during the redirect cycle, which arrives one cycle late.
  - `dmem_stall` in FLUSH2: outputs held at 0 and the state is held, so `fd_flush_second` fires on the first unstalled cycle.
  - A new `ex_redirect` in FLUSH2 takes priority: the row 2 outputs apply and the state remains FLUSH2.
  - Otherwise go to RUN.
- HALT: `pc_we=0`, `fd_we=0`, `de_bubble=1`. Only `rst_n` exits HALT.
- `de_bubble` and `id_halt`:
  - In FLUSH2, `id_halt` is ignored because the instruction is on the wrong path.
  - `de_bubble` is only a D/X kill; the F/D flush markers never clear a stall.
- Counters:
  - `stall_cnt` increments in RUN whenever `pc_we=0`.
  - `flush_cnt` increments on each cycle where row 2 of RUN, or a redirect in FLUSH2, applies.
  - Both saturate at 16'hFFFF and never wrap.

## Timing
- The state register and counters reset asynchronously; the other outputs are combinational from state and inputs.
- Values while `rst_n=0`:
  - State is BOOT, so the BOOT output values apply (`pc_we=1`, `fd_we=1`, `fd_flush=1`, `de_bubble=1`).
  - `pc_sel=0`, `fd_flush_second=0`, `stall_cnt=0`, `flush_cnt=0`.
- Redirect in cycle N: PC loads the target at edge N; `fd_flush=1` in N; `fd_flush_second=1` in N+1; normal fetch resumes in N+2.
- A load-use hazard costs exactly one bubble per hazard cycle, with no added latency beyond the hazard.
- If reset is asserted mid-FLUSH2 or mid-HALT, state goes to BOOT immediately; pending flushes are discarded.

## Structure
- The package holds `PC_W`, `REG_ADDR_W`, the state enum `fd_state_t` and the counter width `PERF_W = 16`.
- One sub-module is natural: `sat_counter` (width parameter, inputs `inc` and `rst_n`). It is instantiated twice.

## Test plan
- Reset release with `rst_n` low for 3 cycles then high: BOOT outputs for one cycle, then `pc_we=1`, `fd_flush=0` in RUN.
- `ex_is_load=1`, `ex_rd=3`, `id_rs=3`, `id_rs_valid=1` for one cycle: `pc_we=0`, `fd_we=0`, `de_bubble=1`, `stall_cnt` goes from 0 to 1.
- `ex_redirect` in cycle N: `pc_sel=1` and `fd_flush=1` in N, `fd_flush_second=1` in N+1, `flush_cnt=1`.
- `ex_redirect` in N with `dmem_stall` high in N+1..N+3: `fd_flush_second` asserts only in N+4; state returns to RUN in N+5.
- `id_halt=1` in RUN: the next cycle and all later cycles show `pc_we=0`; asserting `rst_n=0` returns the block to BOOT.
- Drive 70000 load-use cycles: `stall_cnt` holds at 16'hFFFF.
